// File: rtl/mlp_pkg.sv
// Shared constants and FSM encoding for the MLP job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mlp_pkg;

    // 62 pixel bytes per image; the bias byte is appended above them.
    localparam int IMG_W_DEF = 496;

    // Constant bias input fed to the MLP alongside every image.
    localparam logic [7:0] BIAS = 8'h7F;

    // Label reported when the MLP never answers.
    localparam logic [7:0] TMO_LABEL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MRST  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mlp_seq_if.sv
// Link between the sequencer and the MLP datapath: reset/start pulses and
// the image operand go out, the ready flag and class label come back.
// Latency/backpressure: pure wiring; the MLP answers whenever it is done.
interface mlp_seq_if
    import mlp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF
);
    logic             mlp_rst;    // active-high datapath reset pulse
    logic             mlp_start;  // start pulse
    logic [IMG_W+7:0] mlp_inp;    // {bias, image}
    logic             mlp_ready;  // result valid
    logic [7:0]       mlp_label;  // classification

    modport master (
        output mlp_rst, mlp_start, mlp_inp,
        input  mlp_ready, mlp_label
    );

    modport slave (
        input  mlp_rst, mlp_start, mlp_inp,
        output mlp_ready, mlp_label
    );
endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count visible the cycle after inc/clr.
// Backpressure: none; holds at all-ones once saturated.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,   // asynchronous, active-low
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/mlp_seq.sv
// Sequences one image at a time through an MLP datapath: latch image,
// pulse mlp_rst, pulse mlp_start, wait for mlp_ready (bounded by TMO), hold result.
// Latency: >= 4 cycles accept-to-out_valid; backpressure: in_ready only in IDLE,
// result held in DONE until out_ready. Ports: in_* stream, mlp link, out_* stream, stats.
module mlp_seq
    import mlp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int CNT_W = 16,
    parameter int TMO   = 4096
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMG_W-1:0] in_img,
    input  logic [7:0]       in_label,
    mlp_seq_if.master        mlp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_label,
    output logic             out_match,
    output logic             out_tmo,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] correct_cnt
);
    localparam int TW = $clog2(TMO + 1);

    state_t           state;
    logic [7:0]       label_q;
    logic [TW-1:0]    wait_cnt;
    logic [IMG_W+7:0] inp_q;
    logic             mrst_q;
    logic             start_q;

    logic hit;
    logic tmo_hit;
    logic done_go;
    logic match_now;

    // mlp_ready only matters in WAIT; a late answer in the last allowed
    // WAIT cycle still wins over the timeout.
    assign hit       = (state == WAIT) && mlp.mlp_ready;
    assign tmo_hit   = (state == WAIT) && !mlp.mlp_ready && (wait_cnt == TW'(TMO - 1));
    assign done_go   = hit || tmo_hit;
    assign match_now = hit && (mlp.mlp_label == label_q);

    assign mlp.mlp_rst   = mrst_q;
    assign mlp.mlp_start = start_q;
    assign mlp.mlp_inp   = inp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            label_q   <= '0;
            wait_cnt  <= '0;
            inp_q     <= '0;
            mrst_q    <= 1'b0;
            start_q   <= 1'b0;
            out_valid <= 1'b0;
            out_label <= '0;
            out_match <= 1'b0;
            out_tmo   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is registered, so it comes up one cycle after
                    // reset release and after each output handshake.
                    if (in_valid && in_ready) begin
                        state    <= MRST;
                        in_ready <= 1'b0;
                        label_q  <= in_label;
                        inp_q    <= {BIAS, in_img};
                        mrst_q   <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MRST: begin
                    state   <= START;
                    mrst_q  <= 1'b0;
                    start_q <= 1'b1;
                end
                START: begin
                    state    <= WAIT;
                    start_q  <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (done_go) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_label <= hit ? mlp.mlp_label : TMO_LABEL;
                        out_match <= match_now;
                        out_tmo   <= tmo_hit;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        inp_q     <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    mrst_q    <= 1'b0;
                    start_q   <= 1'b0;
                    inp_q     <= '0;
                end
            endcase
        end
    end

    // Both counters step on the WAIT->DONE transition, so their new value
    // appears together with out_valid.
    sat_cnt #(.W(CNT_W)) u_total (
        .clk (clk),
        .rst (rst),
        .inc (done_go),
        .clr (clr_stats),
        .cnt (total_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_correct (
        .clk (clk),
        .rst (rst),
        .inc (match_now),
        .clr (clr_stats),
        .cnt (correct_cnt)
    );
endmodule

// File: tb/tb_mlp_seq.sv
// Directed bench for mlp_seq: dut_a uses default timing/counters,
// dut_b uses TMO=16 and 2-bit counters for the timeout and saturation cases.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mlp_seq;
    import mlp_pkg::*;

    localparam int IW = 496;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- DUT A: TMO=4096, CNT_W=16 ----------------
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [IW-1:0] a_in_img;
    logic [7:0]    a_in_label, a_out_label;
    logic          a_out_match, a_out_tmo, a_clr;
    logic [15:0]   a_total, a_correct;
    mlp_seq_if #(.IMG_W(IW)) a_if ();

    mlp_seq #(.IMG_W(IW), .CNT_W(16), .TMO(4096)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_img(a_in_img), .in_label(a_in_label),
        .mlp(a_if),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_label(a_out_label),
        .out_match(a_out_match), .out_tmo(a_out_tmo),
        .clr_stats(a_clr), .total_cnt(a_total), .correct_cnt(a_correct)
    );

    // ---------------- DUT B: TMO=16, CNT_W=2 ----------------
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [IW-1:0] b_in_img;
    logic [7:0]    b_in_label, b_out_label;
    logic          b_out_match, b_out_tmo, b_clr;
    logic [1:0]    b_total, b_correct;
    mlp_seq_if #(.IMG_W(IW)) b_if ();

    mlp_seq #(.IMG_W(IW), .CNT_W(2), .TMO(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_img(b_in_img), .in_label(b_in_label),
        .mlp(b_if),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_label(b_out_label),
        .out_match(b_out_match), .out_tmo(b_out_tmo),
        .clr_stats(b_clr), .total_cnt(b_total), .correct_cnt(b_correct)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one image; returns in MRST (one cycle after the accepting edge).
    task automatic a_accept(input logic [IW-1:0] img, input logic [7:0] lab);
        a_in_img = img; a_in_label = lab; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic b_accept(input logic [IW-1:0] img, input logic [7:0] lab);
        b_in_img = img; b_in_label = lab; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
    endtask

    // Full job answered in the first WAIT cycle, consumed immediately.
    task automatic a_job(input logic [IW-1:0] img, input logic [7:0] lab, input logic [7:0] mlab);
        a_accept(img, lab);
        step(); step();
        a_if.mlp_ready = 1'b1; a_if.mlp_label = mlab;
        step();
        a_if.mlp_ready = 1'b0; a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
    endtask

    task automatic b_job(input logic [IW-1:0] img, input logic [7:0] lab, input logic [7:0] mlab);
        b_accept(img, lab);
        step(); step();
        b_if.mlp_ready = 1'b1; b_if.mlp_label = mlab;
        step();
        b_if.mlp_ready = 1'b0; b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_if.mlp_rst !== 1'b0 || a_if.mlp_start !== 1'b0) begin errors++; $display("FAIL rst_pulses: got rst=%b start=%b want 0 0", a_if.mlp_rst, a_if.mlp_start); end
        checks++; if (a_if.mlp_inp !== '0) begin errors++; $display("FAIL rst_mlp_inp: got %h want 0", a_if.mlp_inp); end
        checks++; if (a_out_label !== 8'h00 || a_out_match !== 1'b0 || a_out_tmo !== 1'b0) begin errors++; $display("FAIL rst_out: got label=%h match=%b tmo=%b want 00 0 0", a_out_label, a_out_match, a_out_tmo); end
        checks++; if (a_total !== 16'd0 || a_correct !== 16'd0) begin errors++; $display("FAIL rst_counters: got %0d %0d want 0 0", a_total, a_correct); end
        rst = 1'b1;
        step();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_a: in_ready got %b want 1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_b: in_ready got %b want 1", b_in_ready); end
    endtask

    task automatic test_match();
        logic [IW-1:0] img;
        int early;
        img = {62{8'h10}};
        a_accept(img, 8'd3);
        checks++; if (a_if.mlp_rst !== 1'b1 || a_if.mlp_start !== 1'b0) begin errors++; $display("FAIL match_mrst: got rst=%b start=%b want 1 0", a_if.mlp_rst, a_if.mlp_start); end
        checks++; if (a_if.mlp_inp !== {8'h7F, img}) begin errors++; $display("FAIL match_inp: got %h want 7f + image", a_if.mlp_inp); end
        step();
        checks++; if (a_if.mlp_rst !== 1'b0 || a_if.mlp_start !== 1'b1) begin errors++; $display("FAIL match_start: got rst=%b start=%b want 0 1", a_if.mlp_rst, a_if.mlp_start); end
        step();
        early = 0;
        for (int i = 0; i < 19; i++) begin
            if (a_out_valid !== 1'b0) early++;
            step();
        end
        checks++; if (early != 0) begin errors++; $display("FAIL match_no_early: out_valid high %0d cycles want 0", early); end
        checks++; if (a_if.mlp_inp[IW+7:IW] !== 8'h7F) begin errors++; $display("FAIL match_bias: got %h want 7f", a_if.mlp_inp[IW+7:IW]); end
        a_if.mlp_ready = 1'b1; a_if.mlp_label = 8'd3;
        step();
        a_if.mlp_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL match_valid: got %b want 1", a_out_valid); end
        checks++; if (a_out_label !== 8'd3 || a_out_match !== 1'b1 || a_out_tmo !== 1'b0) begin errors++; $display("FAIL match_result: got label=%0d match=%b tmo=%b want 3 1 0", a_out_label, a_out_match, a_out_tmo); end
        checks++; if (a_total !== 16'd1 || a_correct !== 16'd1) begin errors++; $display("FAIL match_counts: got %0d %0d want 1 1", a_total, a_correct); end
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL match_return: got valid=%b in_ready=%b want 0 1", a_out_valid, a_in_ready); end
        checks++; if (a_if.mlp_inp !== '0) begin errors++; $display("FAIL match_inp_idle: got %h want 0", a_if.mlp_inp); end
    endtask

    task automatic test_mismatch_stall();
        logic [IW-1:0] img;
        img = {62{8'h22}};
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        checks++; if (a_total !== 16'd0 || a_correct !== 16'd0) begin errors++; $display("FAIL clr_idle: got %0d %0d want 0 0", a_total, a_correct); end
        a_accept(img, 8'd5);
        step(); step();
        a_if.mlp_ready = 1'b1; a_if.mlp_label = 8'd2;
        step();
        a_if.mlp_ready = 1'b0; a_if.mlp_label = 8'd5;
        checks++; if (a_out_valid !== 1'b1 || a_out_label !== 8'd2 || a_out_match !== 1'b0) begin errors++; $display("FAIL mis_result: got valid=%b label=%0d match=%b want 1 2 0", a_out_valid, a_out_label, a_out_match); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_label !== 8'd2 || a_out_match !== 1'b0 || a_out_tmo !== 1'b0 || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL mis_stall_%0d: got valid=%b label=%0d match=%b tmo=%b in_ready=%b want 1 2 0 0 0", i, a_out_valid, a_out_label, a_out_match, a_out_tmo, a_in_ready);
            end
        end
        checks++; if (a_total !== 16'd1 || a_correct !== 16'd0) begin errors++; $display("FAIL mis_counts: got %0d %0d want 1 0", a_total, a_correct); end
        a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL mis_hs_in_ready: got %b want 0", a_in_ready); end
        step();
        a_out_ready = 1'b0;
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL mis_return: got in_ready=%b valid=%b want 1 0", a_in_ready, a_out_valid); end
    endtask

    task automatic test_early_ready();
        int n_rst, n_start, lat, early;
        logic [IW-1:0] img;
        img = {31{16'hA55A}};
        a_if.mlp_ready = 1'b1; a_if.mlp_label = 8'd7;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_out_valid !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL early_idle: out_valid high %0d cycles want 0", early); end
        a_accept(img, 8'd7);
        n_rst = 0; n_start = 0; lat = 0;
        for (int k = 1; k <= 6; k++) begin
            if (a_if.mlp_rst === 1'b1) n_rst++;
            if (a_if.mlp_start === 1'b1) n_start++;
            if (a_out_valid === 1'b1 && lat == 0) lat = k;
            if (k < 6) step();
        end
        checks++; if (n_rst != 1 || n_start != 1) begin errors++; $display("FAIL early_pulses: got rst=%0d start=%0d cycles want 1 1", n_rst, n_start); end
        checks++; if (lat != 4) begin errors++; $display("FAIL early_latency: got %0d want 4", lat); end
        checks++; if (a_out_label !== 8'd7 || a_out_match !== 1'b1) begin errors++; $display("FAIL early_result: got label=%0d match=%b want 7 1", a_out_label, a_out_match); end
        checks++; if (a_total !== 16'd2 || a_correct !== 16'd1) begin errors++; $display("FAIL early_counts: got %0d %0d want 2 1", a_total, a_correct); end
        a_if.mlp_ready = 1'b0; a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [IW-1:0] img;
        img = {62{8'h01}};
        a_accept(img, 8'd1);
        step(); step(); step(); step(); step();
        rst = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL abort_ctl: got valid=%b in_ready=%b want 0 0", a_out_valid, a_in_ready); end
        checks++; if (a_if.mlp_inp !== '0 || a_out_label !== 8'h00) begin errors++; $display("FAIL abort_regs: got label=%h inp_top=%h want 00 00", a_out_label, a_if.mlp_inp[IW+7:IW]); end
        checks++; if (a_total !== 16'd0 || a_correct !== 16'd0) begin errors++; $display("FAIL abort_counts: got %0d %0d want 0 0", a_total, a_correct); end
        a_if.mlp_ready = 1'b1; a_if.mlp_label = 8'd1;
        step(); step();
        rst = 1'b1;
        step();
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL abort_release: got in_ready=%b valid=%b want 1 0", a_in_ready, a_out_valid); end
        step();
        checks++; if (a_out_valid !== 1'b0 || a_total !== 16'd0) begin errors++; $display("FAIL abort_no_result: got valid=%b total=%0d want 0 0", a_out_valid, a_total); end
        a_if.mlp_ready = 1'b0;
    endtask

    task automatic test_clr_stats();
        logic [IW-1:0] img;
        img = {62{8'h33}};
        a_job(img, 8'd4, 8'd4);
        checks++; if (a_total !== 16'd1 || a_correct !== 16'd1) begin errors++; $display("FAIL clr_pre: got %0d %0d want 1 1", a_total, a_correct); end
        a_accept(img, 8'd6);
        step(); step();
        a_if.mlp_ready = 1'b1; a_if.mlp_label = 8'd6; a_clr = 1'b1;
        step();
        a_if.mlp_ready = 1'b0; a_clr = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_out_match !== 1'b1) begin errors++; $display("FAIL clr_done: got valid=%b match=%b want 1 1", a_out_valid, a_out_match); end
        checks++; if (a_total !== 16'd0 || a_correct !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0d %0d want 0 0", a_total, a_correct); end
        step();
        checks++; if (a_total !== 16'd0 || a_correct !== 16'd0) begin errors++; $display("FAIL clr_hold: got %0d %0d want 0 0", a_total, a_correct); end
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic [IW-1:0] img;
        int early;
        img = {62{8'h44}};
        b_accept(img, 8'd9);
        step(); step();
        early = 0;
        for (int i = 0; i < 15; i++) begin
            if (b_out_valid !== 1'b0) early++;
            step();
        end
        if (b_out_valid !== 1'b0) early++;
        checks++; if (early != 0) begin errors++; $display("FAIL tmo_early: out_valid high %0d WAIT cycles want 0", early); end
        step();
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid: got %b want 1", b_out_valid); end
        checks++; if (b_out_label !== 8'hFF || b_out_tmo !== 1'b1 || b_out_match !== 1'b0) begin errors++; $display("FAIL tmo_result: got label=%h tmo=%b match=%b want ff 1 0", b_out_label, b_out_tmo, b_out_match); end
        checks++; if (b_total !== 2'd1 || b_correct !== 2'd0) begin errors++; $display("FAIL tmo_counts: got %0d %0d want 1 0", b_total, b_correct); end
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;

        b_accept(img, 8'd9);
        step(); step();
        for (int i = 0; i < 15; i++) step();
        b_if.mlp_ready = 1'b1; b_if.mlp_label = 8'd9;
        step();
        b_if.mlp_ready = 1'b0;
        checks++; if (b_out_valid !== 1'b1 || b_out_label !== 8'd9 || b_out_tmo !== 1'b0 || b_out_match !== 1'b1) begin errors++; $display("FAIL tmo_edge: got valid=%b label=%h tmo=%b match=%b want 1 09 0 1", b_out_valid, b_out_label, b_out_tmo, b_out_match); end
        checks++; if (b_total !== 2'd2 || b_correct !== 2'd1) begin errors++; $display("FAIL tmo_edge_counts: got %0d %0d want 2 1", b_total, b_correct); end
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        logic [IW-1:0] img;
        logic [1:0] exp_cnt;
        img = {62{8'h55}};
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            b_job(img, 8'd2, 8'd2);
            exp_cnt = (n < 3) ? 2'(n) : 2'd3;
            checks++; if (b_total !== exp_cnt) begin errors++; $display("FAIL sat_total_%0d: got %0d want %0d", n, b_total, exp_cnt); end
        end
        checks++; if (b_correct !== 2'd3) begin errors++; $display("FAIL sat_correct: got %0d want 3", b_correct); end
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_img = '0; a_in_label = '0; a_out_ready = 1'b0; a_clr = 1'b0;
        b_in_valid = 1'b0; b_in_img = '0; b_in_label = '0; b_out_ready = 1'b0; b_clr = 1'b0;
        a_if.mlp_ready = 1'b0; a_if.mlp_label = '0;
        b_if.mlp_ready = 1'b0; b_if.mlp_label = '0;

        test_reset();
        test_match();
        test_mismatch_stall();
        test_early_ready();
        test_reset_abort();
        test_clr_stats();
        test_timeout();
        test_saturate();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
